// File: rtl/pdm_breath_sequencer.sv
// rtl/pdm_breath_sequencer.sv - brightness level sequencer feeding the PDM LED driver
//
// Purpose: emits a LEVEL_W-bit level plus a one-cycle write strobe every
// (BASE_PERIOD << speed) enabled cycles. The level follows a triangle,
// sawtooth, fixed or blink pattern chosen by mode.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   en          in   run enable; low freezes counter, level and direction
//   mode        in   00 triangle, 01 sawtooth, 10 fixed, 11 blink
//   speed       in   update period = BASE_PERIOD << speed
//   fixed_level in   level used in fixed mode
//   level_out   out  current level, registered
//   write_en    out  one-cycle strobe when level_out takes a new value
//   dir_up      out  triangle direction, 1 = rising
module pdm_breath_sequencer #(
    parameter int LEVEL_W     = 5,
    parameter int BASE_PERIOD = 16,
    parameter int CNT_W       = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    input  logic [LEVEL_W-1:0] fixed_level,
    output logic [LEVEL_W-1:0] level_out,
    output logic               write_en,
    output logic               dir_up
);

    localparam logic [LEVEL_W-1:0] MAXL = '1;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    dir_t               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   reload;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               we_q, we_d;
    logic               fresh_q, fresh_d;
    logic               update;

    assign reload = CNT_W'((BASE_PERIOD << speed) - 1);

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        dir_d   = dir_q;
        we_d    = 1'b0;
        fresh_d = 1'b0;
        update  = 1'b0;

        // The reload value depends on speed, so it cannot be an async reset
        // constant. Instead the first edge after reset release loads it,
        // already counting that edge as a decrement when en is high.
        if (fresh_q) begin
            cnt_d = en ? (reload - CNT_W'(1)) : reload;
        end else if (en) begin
            if (cnt_q == '0) begin
                update = 1'b1;
                cnt_d  = reload;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (update) begin
            we_d = 1'b1;
            case (mode)
                2'b00: begin
                    // Turnaround emits MAXL-1 / 1 so each extreme appears once.
                    if (dir_q == DIR_UP) begin
                        if (level_q == MAXL) begin
                            dir_d   = DIR_DOWN;
                            level_d = MAXL - LEVEL_W'(1);
                        end else begin
                            level_d = level_q + LEVEL_W'(1);
                        end
                    end else begin
                        if (level_q == '0) begin
                            dir_d   = DIR_UP;
                            level_d = LEVEL_W'(1);
                        end else begin
                            level_d = level_q - LEVEL_W'(1);
                        end
                    end
                end
                2'b01:   level_d = (level_q == MAXL) ? '0 : (level_q + LEVEL_W'(1));
                2'b10:   level_d = fixed_level;
                default: level_d = (level_q == '0) ? MAXL : '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= '0;
            dir_q   <= DIR_UP;
            we_q    <= 1'b0;
            fresh_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            we_q    <= we_d;
            fresh_q <= fresh_d;
        end
    end

    assign level_out = level_q;
    assign write_en  = we_q;
    assign dir_up    = (dir_q == DIR_UP);

endmodule

// File: tb/tb_pdm_breath_sequencer.sv
// tb/tb_pdm_breath_sequencer.sv - self-checking bench for pdm_breath_sequencer
module tb_pdm_breath_sequencer;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [4:0] fixed_level;
    logic [4:0] level_out;
    logic       write_en;
    logic       dir_up;

    pdm_breath_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .speed       (speed),
        .fixed_level (fixed_level),
        .level_out   (level_out),
        .write_en    (write_en),
        .dir_up      (dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: counts enabled edges remaining until the next update.
    int   m_rem;
    int   m_lvl;
    bit   m_up;
    bit   m_we;
    bit   m_fresh;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [1:0] speed;
        logic [4:0] fix;
        int         cycles;
        logic [4:0] lvl;
        logic       we;
        logic       up;
    } vec_t;

    vec_t tbl [0:15];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return {25'd0, level_out, write_en, dir_up};
    endfunction

    function automatic int model_outs();
        return {25'd0, 5'(m_lvl), m_we, m_up};
    endfunction

    task automatic model_update();
        case (mode)
            2'b00: begin
                if (m_up) begin
                    if (m_lvl == 31) begin m_up = 1'b0; m_lvl = 30; end
                    else m_lvl = m_lvl + 1;
                end else begin
                    if (m_lvl == 0) begin m_up = 1'b1; m_lvl = 1; end
                    else m_lvl = m_lvl - 1;
                end
            end
            2'b01:   m_lvl = (m_lvl == 31) ? 0 : m_lvl + 1;
            2'b10:   m_lvl = int'(fixed_level);
            default: m_lvl = (m_lvl == 0) ? 31 : 0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        if (m_fresh) begin
            m_rem   = 16 << speed;
            m_fresh = 1'b0;
        end
        m_we = 1'b0;
        if (en) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                model_update();
                m_we  = 1'b1;
                m_rem = 16 << speed;
            end
        end
        #1;
        check("model", outs(), model_outs());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_lvl = 0;
        m_up  = 1'b1;
        m_we  = 1'b0;
        check("async_reset", outs(), {25'd0, 5'd0, 1'b0, 1'b1});
        @(negedge clk);
        reset   = 1'b0;
        m_fresh = 1'b1;
    endtask

    task automatic wait_strobe(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!write_en && n < bound);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        en          = 1'b1;
        mode        = 2'b00;
        speed       = 2'd0;
        fixed_level = 5'd0;

        //          en    mode   spd   fix     cyc  lvl    we    up
        tbl[0]  = '{1'b1, 2'd0, 2'd0, 5'h00,   15, 5'd0,  1'b0, 1'b1};
        tbl[1]  = '{1'b1, 2'd0, 2'd0, 5'h00,    1, 5'd1,  1'b1, 1'b1};
        tbl[2]  = '{1'b1, 2'd0, 2'd0, 5'h00,    1, 5'd1,  1'b0, 1'b1};
        tbl[3]  = '{1'b1, 2'd0, 2'd0, 5'h00,   15, 5'd2,  1'b1, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 2'd0, 5'h00,  464, 5'd31, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 2'd0, 2'd0, 5'h00,   16, 5'd30, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 2'd1, 2'd2, 5'h00,   16, 5'd31, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 2'd2, 5'h00,   64, 5'd0,  1'b1, 1'b0};
        tbl[8]  = '{1'b1, 2'd1, 2'd2, 5'h00,   64, 5'd1,  1'b1, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 2'd0, 5'h00,   64, 5'd0,  1'b1, 1'b0};
        tbl[10] = '{1'b1, 2'd3, 2'd0, 5'h00,   16, 5'd31, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 2'd0, 2'd0, 5'h00,   16, 5'd30, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 2'd2, 2'd1, 5'h1a,   16, 5'h1a, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 2'd2, 2'd1, 5'h1a,   32, 5'h1a, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 2'd2, 2'd1, 5'h0f,   20, 5'h1a, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 2'd2, 2'd1, 5'h0f,   32, 5'h0f, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            en          = tbl[i].en;
            mode        = tbl[i].mode;
            speed       = tbl[i].speed;
            fixed_level = tbl[i].fix;
            for (int c = 0; c < tbl[i].cycles; c++) step();
            check($sformatf("vec%0d", i), outs(), {25'd0, tbl[i].lvl, tbl[i].we, tbl[i].up});
        end
        step();
        check("strobe_one_cycle", int'(write_en), 0);

        // Mid-count speed change, then an en gap delaying the strobe.
        en = 1'b1; mode = 2'b01; speed = 2'd0;
        do_reset();
        repeat (5) step();
        speed = 2'd3;
        wait_strobe(200, n);
        check("speed_change_cur_period", n, 11);
        wait_strobe(200, n);
        check("speed_change_next_period", n, 128);
        repeat (7) step();
        en = 1'b0;
        repeat (20) step();
        en = 1'b1;
        wait_strobe(200, n);
        check("en_gap_delay", n, 121);

        // Blink into triangle at 31 while rising.
        mode = 2'b00; speed = 2'd0;
        do_reset();
        mode = 2'b11;
        wait_strobe(40, n);
        check("blink_to_max", int'(level_out), 31);
        mode = 2'b00;
        wait_strobe(40, n);
        check("tri_resume_down", {27'd0, level_out, dir_up}, {27'd0, 5'd30, 1'b0});

        // Reset mid-sweep while the strobe for level 17 is high.
        mode = 2'b00; speed = 2'd0;
        do_reset();
        n = 0;
        while (!(level_out == 5'd17 && write_en) && n < 400) begin
            step();
            n++;
        end
        check("reach_level17", int'(level_out == 5'd17 && write_en), 1);
        #2;
        do_reset();
        wait_strobe(40, n);
        check("restart_first_strobe", n, 16);
        check("restart_level", int'(level_out), 1);

        // Randomized run against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) < 3) mode = 2'($urandom);
            if ($urandom_range(0, 99) < 2) speed = 2'($urandom);
            if ($urandom_range(0, 99) < 5) fixed_level = 5'($urandom);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdm_breath_sequencer.md
Name: pdm_breath_sequencer

Overview:
Upstream level generator for the PDM LED driver. Produces a 5-bit brightness level plus a one-cycle write strobe at a programmable update rate, sweeping the level in triangle ("breathing"), sawtooth, blink or fixed patterns. Its outputs connect directly to the driver's level-input and write-enable pins. No software involvement is needed after the mode is set.

Parameters:
LEVEL_W, 5, width of level_out; maximum level MAXL = 2^LEVEL_W-1 (31)
BASE_PERIOD, 16, update period in clk cycles at speed=0; must be a power of two
CNT_W, 7, hold-counter width; must hold BASE_PERIOD*8-1

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
en  input  1  run enable; low freezes counter and level
mode  input  2  00 triangle, 01 sawtooth, 10 fixed, 11 blink
speed  input  2  update period = BASE_PERIOD << speed (16/32/64/128 cycles)
fixed_level  input  LEVEL_W  level used in mode 10
level_out  output  LEVEL_W  current level, registered
write_en  output  1  one-cycle strobe, high in the cycle level_out takes a new value
dir_up  output  1  triangle direction state, 1 = rising

Behaviour:
- Reset (async assert, applies immediately): level_out=0, write_en=0, dir_up=1, hold counter=(BASE_PERIOD<<speed)-1 using speed as sampled at reset release.
- Hold counter: decrements on every clk edge with en=1. On an en=1 edge with counter==0, the block performs an update.
  - Update: level_out<=next, write_en<=1 for exactly that one following cycle, counter<=(BASE_PERIOD<<speed)-1 using the current speed.
- speed and mode are sampled only at an update. A mid-count change affects the next computed level and the next reload, not the running count.
- en=0: counter, level_out and dir_up hold; write_en=0. If en drops in the cycle a strobe is already registered, that strobe still completes its single cycle.
- First strobe after reset release comes on the P-th en-cycle edge, where P = period. Strobe spacing is exactly P cycles while en stays high.
- Next-level rules, all unsigned in LEVEL_W bits, no overflow allowed:
  - Triangle, dir_up=1: level<MAXL gives next=level+1. Level==MAXL gives dir_up<=0 and next=MAXL-1. The peak is emitted once, not repeated.
  - Triangle, dir_up=0: level>0 gives next=level-1. Level==0 gives dir_up<=1 and next=1. The trough is emitted once.
  - Triangle full cycle is therefore 2*MAXL updates (62).
  - Sawtooth: next = (level==MAXL) ? 0 : level+1. dir_up unchanged.
  - Fixed: next=fixed_level. The strobe still fires every period, even if the value is unchanged. dir_up unchanged.
  - Blink: next = (level==0) ? MAXL : 0. Any nonzero level goes to 0. dir_up unchanged.
- Switching into triangle resumes from the current level_out and the stored dir_up, with the same boundary rules. A level at MAXL with dir_up=1 goes down next.
- write_en is never high for two consecutive cycles, because P>=16.
- Implementation: two-state direction FSM (UP/DOWN) plus hold counter and level register; no combinational path from inputs to outputs.

Test Plan:
- Reset, en=1, mode=00, speed=0 -> first strobe 16 cycles after reset release with level_out=1. Levels 1..31 then 30..0 then 1, strobes 16 cycles apart. dir_up falls at the update producing 30.
- mode=01, speed=2 -> strobes 64 cycles apart; level_out steps 1..31, 0, 1. dir_up stays 1.
- mode=10, fixed_level=0x1a, speed=1 -> level_out=0x1a at the first strobe, repeated every 32 cycles. Changing to 0x0f mid-period shows 0x0f only at the next strobe.
- mode=11 starting at level 0 -> alternates 31/0 on each strobe. Switching to 00 while level=31 and dir_up=1 -> next level 30, dir_up=0.
- Drop en for 20 cycles mid-count -> no strobes, and the outputs and counter are frozen. The strobe is delayed by exactly 20 cycles. Speed changed 0→3 mid-count -> current period unchanged, next period 128.
- Assert reset mid-sweep (level=17, write_en high) -> level_out=0, write_en=0, dir_up=1 immediately without a clock edge. Restart timing matches the first scenario.
